// File: rtl/divn_if.sv
// divn_if -- handshake and data bundle for the divn divider.
//   start        request to begin a division (honoured only while ready=1)
//   a_in, b_in   unsigned dividend / divisor, sampled on the accepting edge
//   ready        divider idle, result outputs valid
//   q_out, r_out registered quotient / remainder
//   div0         registered flag, last result came from a zero divisor
// master: the requester; slave: the divider.
interface divn_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic [NBITS-1:0] a_in;
    logic [NBITS-1:0] b_in;
    logic             ready;
    logic [NBITS-1:0] q_out;
    logic [NBITS-1:0] r_out;
    logic             div0;

    modport master (
        output start, a_in, b_in,
        input  ready, q_out, r_out, div0
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, q_out, r_out, div0
    );
endinterface

// File: rtl/divn.sv
// divn -- unsigned NBITS/NBITS restoring divider, one quotient bit per clock.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  divn_if.slave: start/a_in/b_in in, ready/q_out/r_out/div0 out
// Zero dividend or zero divisor takes a one-cycle shortcut; otherwise the
// result is ready NBITS cycles after the accepting edge.
//
// state | meaning
// IDLE  | ready=1, results valid, waiting for start
// SHORT | one-cycle shortcut for a==0 or b==0
// CALC  | shift-subtract iterations, NBITS cycles
module divn #(
    parameter int NBITS = 8
) (
    input  logic  clk,
    input  logic  rst,
    divn_if.slave bus
);
    localparam int CNT_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        CALC  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             idle;
    logic             accept;
    logic             cnt_last;
    logic             qbit;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] a_work;
    logic [NBITS-1:0] b_work;
    logic [NBITS-1:0] r_work;
    logic [NBITS:0]   p;
    logic [NBITS-1:0] r_step;
    logic [NBITS-1:0] q_step;
    logic [NBITS-1:0] q_reg;
    logic [NBITS-1:0] r_reg;
    logic             div0_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idle       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (bus.start) begin
                    accept = 1'b1;
                    if ((bus.a_in == '0) || (bus.b_in == '0)) begin
                        state_next = SHORT;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            SHORT: begin
                state_next = IDLE;
            end
            CALC: begin
                if (cnt_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // a_work doubles as the dividend shifter and the quotient accumulator:
    // each iteration consumes its MSB and shifts the new quotient bit in at
    // the LSB. The partial remainder stays below b, so P < 2b and the
    // NBITS-wide subtraction cannot wrap when it is taken.
    always_comb begin
        cnt_last = (cnt == CNT_W'(NBITS - 1));
        p        = {r_work, a_work[NBITS-1]};
        qbit     = (p >= {1'b0, b_work});
        r_step   = qbit ? (p[NBITS-1:0] - b_work) : p[NBITS-1:0];
        q_step   = {a_work[NBITS-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_work <= '0;
            b_work <= '0;
            r_work <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                a_work <= bus.a_in;
                b_work <= bus.b_in;
                r_work <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                a_work <= q_step;
                r_work <= r_step;
                if (!cnt_last) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Results move only at completion, so the previous answer stays visible
    // while a new operation runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= '0;
            r_reg    <= '0;
            div0_reg <= 1'b0;
        end else if (state == SHORT) begin
            if (b_work == '0) begin
                q_reg    <= '1;
                r_reg    <= a_work;
                div0_reg <= 1'b1;
            end else begin
                q_reg    <= '0;
                r_reg    <= '0;
                div0_reg <= 1'b0;
            end
        end else if ((state == CALC) && cnt_last) begin
            q_reg    <= q_step;
            r_reg    <= r_step;
            div0_reg <= 1'b0;
        end
    end

    assign bus.ready = idle;
    assign bus.q_out = q_reg;
    assign bus.r_out = r_reg;
    assign bus.div0  = div0_reg;
endmodule

// File: tb/tb_divn.sv
// tb_divn -- self-checking bench for divn (NBITS=8): directed cases with
// literal expectations plus a randomized run against an arithmetic model.
module tb_divn;
    localparam int NBITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    divn_if #(.NBITS(NBITS)) bus ();

    divn #(.NBITS(NBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: results from / and %, latency as a cycle countdown.
    logic             m_busy = 1'b0;
    int               m_left = 0;
    int               m_ops  = 0;
    logic             m_done = 1'b0;
    logic [NBITS-1:0] m_q    = '0;
    logic [NBITS-1:0] m_r    = '0;
    logic             m_div0 = 1'b0;
    logic [NBITS-1:0] p_a, p_b, p_q, p_r;
    logic             p_div0;

    always @(posedge clk or posedge rst) begin
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_q    = '0;
            m_r    = '0;
            m_div0 = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_q    = p_q;
                m_r    = p_r;
                m_div0 = p_div0;
                m_done = 1'b1;
            end
        end else if (bus.start) begin
            p_a = bus.a_in;
            p_b = bus.b_in;
            if (p_b == 0) begin
                p_q    = '1;
                p_r    = p_a;
                p_div0 = 1'b1;
            end else begin
                p_q    = p_a / p_b;
                p_r    = p_a % p_b;
                p_div0 = 1'b0;
            end
            m_left = ((p_a == 0) || (p_b == 0)) ? 1 : NBITS;
            m_busy = 1'b1;
            m_ops++;
        end
    end

    always @(negedge clk) begin
        check("ready", bus.ready, !m_busy);
        check("q_out", bus.q_out, m_q);
        check("r_out", bus.r_out, m_r);
        check("div0", bus.div0, m_div0);
        if (m_done && (p_b != 0)) begin
            check("identity_qb_plus_r", int'(bus.q_out) * int'(p_b) + int'(bus.r_out), int'(p_a));
            check("rem_below_divisor", bus.r_out < p_b, 1);
        end
    end

    // Called at posedge+2 with the divider idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_cyc,
                          input logic [7:0] eq, input logic [7:0] er, input logic ed,
                          input int inject);
        int cycles;
        check("ready_before_start", bus.ready, 1);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.a_in  = 8'($urandom);
        bus.b_in  = 8'($urandom);
        check("busy_after_accept", bus.ready, 0);
        cycles = 0;
        while (!bus.ready && cycles < 40) begin
            @(posedge clk);
            #2;
            cycles++;
            if (cycles == inject) begin
                bus.start = 1'b1;
                bus.a_in  = 8'd9;
                bus.b_in  = 8'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("latency", cycles, exp_cyc);
        check("lit_q", bus.q_out, eq);
        check("lit_r", bus.r_out, er);
        check("lit_div0", bus.div0, ed);
    endtask

    initial begin
        int goal;
        int waited;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_ready", bus.ready, 1);
        check("reset_q", bus.q_out, 0);
        check("reset_r", bus.r_out, 0);
        check("reset_div0", bus.div0, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_op(8'd100, 8'd7, 8, 8'd14, 8'd2, 1'b0, -1);
        run_op(8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0, -1);
        run_op(8'd200, 8'd13, 8, 8'd15, 8'd5, 1'b0, -1);
        run_op(8'd5, 8'd0, 1, 8'd255, 8'd5, 1'b1, -1);
        run_op(8'd0, 8'd9, 1, 8'd0, 8'd0, 1'b0, -1);
        run_op(8'd100, 8'd7, 8, 8'd14, 8'd2, 1'b0, 3);

        // Abort mid-operation with an asynchronous reset.
        bus.start = 1'b1;
        bus.a_in  = 8'd200;
        bus.b_in  = 8'd13;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        check("busy_before_abort", bus.ready, 0);
        rst = 1'b1;
        #1;
        check("abort_ready", bus.ready, 1);
        check("abort_q", bus.q_out, 0);
        check("abort_r", bus.r_out, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        run_op(8'd9, 8'd4, 8, 8'd2, 8'd1, 1'b0, -1);

        // Randomized run: start, operands and zero cases all vary every cycle.
        goal = m_ops + 1000;
        for (int c = 0; c < 30000 && m_ops < goal; c++) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.a_in  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            case ($urandom_range(0, 7))
                0:       bus.b_in = 8'd0;
                1, 2, 3: bus.b_in = 8'($urandom_range(1, 15));
                default: bus.b_in = 8'($urandom);
            endcase
            @(posedge clk);
            #2;
        end
        bus.start = 1'b0;
        check("random_ops_done", m_ops >= goal, 1);
        waited = 0;
        while (!bus.ready && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("final_idle", bus.ready, 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/divn.md
DIVN -- requirements
Module: divn

Interface
REQ-001 Parameter NBITS, default 8: operand, quotient and remainder width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin a division; sampled only while ready=1.
REQ-005 a_in  input  NBITS  dividend, unsigned; sampled on the accepting edge.
REQ-006 b_in  input  NBITS  divisor, unsigned; sampled on the accepting edge.
REQ-007 ready  output  1  high when idle and the result outputs are valid.
REQ-008 q_out  output  NBITS  quotient, registered.
REQ-009 r_out  output  NBITS  remainder, registered.
REQ-010 div0  output  1  registered flag; high when the last result came from a zero divisor.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHORT and CALC; ready=1 only in IDLE.
REQ-012 Accept: a rising edge with state IDLE and start=1 SHALL capture a_in and b_in into internal working registers and leave IDLE.
REQ-013 Accept target: SHORT if a_in==0 or b_in==0, otherwise CALC.
REQ-014 SHORT SHALL last exactly one cycle and then go to IDLE.
REQ-015 SHORT with b==0 SHALL load q_out to all ones, r_out to a, and div0 to 1.
REQ-016 SHORT with a==0 and b!=0 SHALL load q_out=0, r_out=0, div0=0.
REQ-017 CALC SHALL perform restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly NBITS cycles.
REQ-018 Iteration counter SHALL be ceil(log2(NBITS+1)) bits wide, cleared on accept, and wrap-free.
REQ-019 Each CALC cycle: P = {R, next dividend bit}, with P NBITS+1 bits wide; if P >= b then R <= P-b and qbit=1; else R <= P[NBITS-1:0] and qbit=0.
REQ-020 No intermediate value SHALL overflow its width.
REQ-021 On the last CALC cycle, q_out, r_out and div0=0 SHALL load from the working registers, and the state SHALL return to IDLE.
REQ-022 q_out, r_out and div0 SHALL change only at completion (end of SHORT or last CALC) or on reset; they hold the previous result while busy.
REQ-023 Latency, start accepted at edge k:
  - ready=0 from after edge k;
  - CALC path: ready=1 and results valid after edge k+NBITS;
  - SHORT path: ready=1 and results valid after edge k+1.
REQ-024 start while busy (SHORT or CALC) SHALL be ignored, with no effect on the running operation.
REQ-025 a_in and b_in changes after the accepting edge SHALL have no effect on the running operation.
REQ-026 start held high continuously SHALL begin a new operation on the first edge in IDLE; results of the previous operation are visible for one cycle.
REQ-027 Results SHALL satisfy q*b + r == a and r < b for every b != 0.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force:
  - state IDLE, ready=1;
  - q_out=0, r_out=0, div0=0;
  - working registers and counter to 0.
REQ-029 rst asserted mid-operation SHALL abort the operation; no partial result SHALL appear on q_out/r_out.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (NBITS=8)
REQ-031 a=100, b=7, start pulsed 1 cycle -> ready low 8 cycles, then q_out=14, r_out=2, div0=0, ready=1.
REQ-032 a=255, b=1 -> after 8 cycles q_out=255, r_out=0; then a=200, b=13 -> q_out=15, r_out=5.
REQ-033 a=5, b=0 -> ready low 1 cycle, then q_out=255, r_out=5, div0=1; a=0, b=9 -> 1 cycle, q_out=0, r_out=0, div0=0.
REQ-034 a=100, b=7 accepted; at cycle 3 drive start=1 with a=9, b=3 -> ignored; final q_out=14, r_out=2 at cycle 8.
REQ-035 a=200, b=13 accepted; rst pulsed at cycle 4 -> ready=1 and q_out=r_out=0 immediately; next start with a=9, b=4 -> q_out=2, r_out=1.
REQ-036 Random a, b over 1000 operations with a scoreboard checking REQ-027 and the REQ-023 latency.
